// File: rtl/dec_pipe_if.sv
// Handshake and decoded-field bundle between fetch, the decode stage and register-read.
interface dec_pipe_if #(
  parameter int unsigned OP_W   = 5,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned INST_W = 20,
  parameter int unsigned CNT_W  = 8
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [OP_W-1:0]      in_op;
  logic [INST_W-1:0]    in_inst;
  logic                 out_valid;
  logic                 out_ready;
  logic [1:0]           out_cls;
  logic [REG_W-1:0]     rd;
  logic [REG_W-1:0]     rs;
  logic [REG_W-1:0]     rt;
  logic [3*REG_W-1:0]   bamt;
  logic                 we_rf;
  logic                 we_dmem;
  logic [CNT_W-1:0]     stall_cnt;

  // Environment side: drives instructions, flush and downstream ready.
  modport master (
    output flush, in_valid, in_op, in_inst, out_ready,
    input  in_ready, out_valid, out_cls, rd, rs, rt, bamt, we_rf, we_dmem, stall_cnt
  );

  // Decode stage side.
  modport slave (
    input  flush, in_valid, in_op, in_inst, out_ready,
    output in_ready, out_valid, out_cls, rd, rs, rt, bamt, we_rf, we_dmem, stall_cnt
  );
endinterface

// File: rtl/dec_pipe.sv
// Registered instruction decode stage with valid/ready flow control, flush,
// load-use interlock (one bubble) and a saturating bubble counter.
module dec_pipe #(
  parameter int unsigned OP_W   = 5,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned INST_W = 20,
  parameter int unsigned OP_LD  = 12,
  parameter int unsigned OP_ST  = 13,
  parameter int unsigned OP_RX  = 11,
  parameter int unsigned CNT_W  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  dec_pipe_if.slave  bus
);

  localparam int unsigned F_W = 3 * REG_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {CLS_R = 2'd0, CLS_LD = 2'd1, CLS_ST = 2'd2, CLS_JMP = 2'd3} cls_e;

  cls_e             w_cls;
  logic [F_W-1:0]   w_f;
  logic [REG_W-1:0] w_f2, w_f1, w_f0;
  logic [REG_W-1:0] w_rd, w_rs, w_rt;
  logic [F_W-1:0]   w_bamt;
  logic             w_we_rf, w_we_dmem;
  logic             w_hit, w_hazard, w_ready, w_accept;

  cls_e             r_cls;
  logic             r_valid;
  logic [REG_W-1:0] r_rd, r_rs, r_rt;
  logic [F_W-1:0]   r_bamt;
  logic             r_we_rf, r_we_dmem;
  logic [CNT_W-1:0] r_stall;

  assign w_f  = bus.in_inst[F_W-1:0];
  assign w_f2 = w_f[F_W-1 -: REG_W];
  assign w_f1 = w_f[2*REG_W-1 -: REG_W];
  assign w_f0 = w_f[REG_W-1:0];

  // Payload bits above the packed register fields carry nothing this stage uses.
  if (INST_W > F_W) begin : g_unused
    logic w_unused_hi;
    assign w_unused_hi = ^bus.in_inst[INST_W-1:F_W];
  end

  // Instruction class from opcode; anything not R/LOAD/STORE is a jump.
  always_comb begin
    w_cls = CLS_JMP;
    if (bus.in_op == OP_W'(OP_LD))
      w_cls = CLS_LD;
    else if (bus.in_op == OP_W'(OP_ST))
      w_cls = CLS_ST;
    else if ((bus.in_op < OP_W'(7)) || (bus.in_op == OP_W'(OP_RX)))
      w_cls = CLS_R;
  end

  // Field split per class; unused fields forced to zero so nothing stale is registered.
  always_comb begin
    w_rd      = '0;
    w_rs      = '0;
    w_rt      = '0;
    w_bamt    = '0;
    w_we_rf   = 1'b0;
    w_we_dmem = 1'b0;
    case (w_cls)
      CLS_R:   begin w_rd = w_f2; w_rs = w_f1; w_rt = w_f0; w_we_rf = 1'b1; end
      CLS_LD:  begin w_rd = w_f2; w_rt = w_f1; w_rs = w_f0; w_we_rf = 1'b1; end
      CLS_ST:  begin w_rs = w_f2; w_rd = w_f1; w_we_dmem = 1'b1; end
      default: begin w_bamt = w_f; end
    endcase
  end

  // Load-use check: does the incoming instruction read the held load's destination.
  always_comb begin
    w_hit = 1'b0;
    case (w_cls)
      CLS_R:   w_hit = (w_rs == r_rd) || (w_rt == r_rd);
      CLS_LD:  w_hit = (w_rs == r_rd);
      CLS_ST:  w_hit = (w_rs == r_rd) || (w_rd == r_rd);
      default: w_hit = 1'b0;
    endcase
  end

  assign w_hazard = r_valid && (r_cls == CLS_LD) && (r_rd != '0) && w_hit;
  assign w_ready  = (!r_valid || bus.out_ready) && !w_hazard && !bus.flush;
  assign w_accept = bus.in_valid && w_ready;

  // Output register: flush wins, then accept, then drain on downstream ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_cls     <= CLS_R;
      r_rd      <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_bamt    <= '0;
      r_we_rf   <= 1'b0;
      r_we_dmem <= 1'b0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_cls     <= w_cls;
      r_rd      <= w_rd;
      r_rs      <= w_rs;
      r_rt      <= w_rt;
      r_bamt    <= w_bamt;
      r_we_rf   <= w_we_rf;
      r_we_dmem <= w_we_dmem;
    end else if (r_valid && bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Bubble counter: a hazard with downstream ready drains the load and leaves a gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall <= '0;
    else if (w_hazard && bus.out_ready && !bus.flush && (r_stall != CNT_MAX))
      r_stall <= r_stall + CNT_W'(1);
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_valid;
  assign bus.out_cls   = 2'(r_cls);
  assign bus.rd        = r_rd;
  assign bus.rs        = r_rs;
  assign bus.rt        = r_rt;
  assign bus.bamt      = r_bamt;
  assign bus.we_rf     = r_we_rf;
  assign bus.we_dmem   = r_we_dmem;
  assign bus.stall_cnt = r_stall;

endmodule

// File: tb/tb_dec_pipe.sv
// Bench for dec_pipe: directed scenarios plus random traffic against a transaction-level model.
module tb_dec_pipe;

  localparam int unsigned OP_W   = 5;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned INST_W = 20;
  localparam int unsigned CNT_W  = 8;
  localparam int RMASK   = (1 << REG_W) - 1;
  localparam int FMASK   = (1 << (3 * REG_W)) - 1;
  localparam int CNT_TOP = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  dec_pipe_if #(.OP_W(OP_W), .REG_W(REG_W), .INST_W(INST_W), .CNT_W(CNT_W)) bus_if ();

  dec_pipe #(.OP_W(OP_W), .REG_W(REG_W), .INST_W(INST_W), .OP_LD(12), .OP_ST(13),
             .OP_RX(11), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: what the stage should be holding after the last edge.
  bit m_valid;
  int m_cls, m_rd, m_rs, m_rt, m_bamt, m_we_rf, m_we_dmem, m_stall;
  bit last_rdy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int cls_of(input int op);
    if (op == 12) return 1;
    if (op == 13) return 2;
    if (op < 7 || op == 11) return 0;
    return 3;
  endfunction

  // Which architectural registers an instruction sources, straight from the raw fields.
  function automatic bit reads_reg(input int op, input int inst, input int r);
    int f2, f1, f0;
    f2 = (inst >> (2 * REG_W)) & RMASK;
    f1 = (inst >> REG_W) & RMASK;
    f0 = inst & RMASK;
    case (cls_of(op))
      0: return (f1 == r) || (f0 == r);
      1: return (f0 == r);
      2: return (f2 == r) || (f1 == r);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_load(input int op, input int inst);
    int f2, f1, f0;
    f2 = (inst >> (2 * REG_W)) & RMASK;
    f1 = (inst >> REG_W) & RMASK;
    f0 = inst & RMASK;
    m_cls = cls_of(op);
    m_rd = 0; m_rs = 0; m_rt = 0; m_bamt = 0; m_we_rf = 0; m_we_dmem = 0;
    case (m_cls)
      0: begin m_rd = f2; m_rs = f1; m_rt = f0; m_we_rf = 1; end
      1: begin m_rd = f2; m_rt = f1; m_rs = f0; m_we_rf = 1; end
      2: begin m_rs = f2; m_rd = f1; m_we_dmem = 1; end
      default: m_bamt = inst & FMASK;
    endcase
    m_valid = 1'b1;
  endtask

  task automatic check_fields;
    check_eq("out_cls", 32'(bus_if.out_cls), 32'(m_cls));
    check_eq("rd", 32'(bus_if.rd), 32'(m_rd));
    check_eq("rs", 32'(bus_if.rs), 32'(m_rs));
    check_eq("rt", 32'(bus_if.rt), 32'(m_rt));
    check_eq("bamt", 32'(bus_if.bamt), 32'(m_bamt));
    check_eq("we_rf", 32'(bus_if.we_rf), 32'(m_we_rf));
    check_eq("we_dmem", 32'(bus_if.we_dmem), 32'(m_we_dmem));
  endtask

  // One clock: drive inputs, compare against the model mid-cycle, advance the model.
  task automatic step(input bit v, input int op, input int inst, input bit ordy, input bit fl);
    bit haz, rdy;
    bus_if.in_valid  = v;
    bus_if.in_op     = OP_W'(op);
    bus_if.in_inst   = INST_W'(inst);
    bus_if.out_ready = ordy;
    bus_if.flush     = fl;
    @(negedge clk);
    haz = m_valid && (m_cls == 1) && (m_rd != 0) && reads_reg(op, inst, m_rd);
    rdy = (!m_valid || ordy) && !haz && !fl;
    check_eq("in_ready", 32'(bus_if.in_ready), 32'(rdy));
    check_eq("out_valid", 32'(bus_if.out_valid), 32'(m_valid));
    check_eq("stall_cnt", 32'(bus_if.stall_cnt), 32'(m_stall));
    if (m_valid) check_fields();
    if (fl) begin
      m_valid = 1'b0;
    end else if (v && rdy) begin
      model_load(op, inst);
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
      if (haz && m_stall < CNT_TOP) m_stall++;
    end
    last_rdy = rdy;
    @(posedge clk);
    #1;
  endtask

  // Reset with inputs toggling; everything must read zero and the stage must come back ready.
  task automatic do_reset;
    rst_n = 1'b0;
    repeat (3) begin
      bus_if.in_valid  = 1'($urandom);
      bus_if.in_op     = OP_W'($urandom);
      bus_if.in_inst   = INST_W'($urandom);
      bus_if.out_ready = 1'($urandom);
      bus_if.flush     = 1'($urandom);
      @(negedge clk);
      check_eq("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
      check_eq("rst_stall_cnt", 32'(bus_if.stall_cnt), 32'd0);
      check_eq("rst_cls", 32'(bus_if.out_cls), 32'd0);
      check_eq("rst_rd", 32'(bus_if.rd), 32'd0);
      check_eq("rst_rs", 32'(bus_if.rs), 32'd0);
      check_eq("rst_rt", 32'(bus_if.rt), 32'd0);
      check_eq("rst_bamt", 32'(bus_if.bamt), 32'd0);
      check_eq("rst_we", 32'({bus_if.we_rf, bus_if.we_dmem}), 32'd0);
    end
    bus_if.in_valid  = 1'b0;
    bus_if.flush     = 1'b0;
    bus_if.out_ready = 1'b1;
    rst_n = 1'b1;
    m_valid = 1'b0;
    m_cls = 0; m_rd = 0; m_rs = 0; m_rt = 0; m_bamt = 0; m_we_rf = 0; m_we_dmem = 0;
    m_stall = 0;
    last_rdy = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
    check_eq("rst_rel_valid", 32'(bus_if.out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  int cur_op, cur_inst;
  bit cur_v;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b1;
    bus_if.in_valid = 1'b0; bus_if.in_op = '0; bus_if.in_inst = '0;
    bus_if.out_ready = 1'b0; bus_if.flush = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // R-type split.
    step(1, 3, 'h01443, 1, 0);
    check_eq("r_valid", 32'(bus_if.out_valid), 32'd1);
    check_eq("r_rd", 32'(bus_if.rd), 32'd5);
    check_eq("r_rs", 32'(bus_if.rs), 32'd2);
    check_eq("r_rt", 32'(bus_if.rt), 32'd3);
    check_eq("r_we", 32'({bus_if.we_rf, bus_if.we_dmem}), 32'h2);
    check_eq("r_cls", 32'(bus_if.out_cls), 32'd0);

    // Load rd=4 then R-type reading r4: one bubble.
    step(1, 12, 4 << 10, 1, 0);
    step(1, 3, 4 << 5, 1, 0);
    check_eq("lu_bubble", 32'(bus_if.out_valid), 32'd0);
    check_eq("lu_stall", 32'(bus_if.stall_cnt), 32'd1);
    step(1, 3, 4 << 5, 1, 0);
    check_eq("lu_after", 32'(bus_if.out_valid), 32'd1);
    check_eq("lu_after_rs", 32'(bus_if.rs), 32'd4);

    // Load to r0 never interlocks.
    step(1, 12, 'h00021, 1, 0);
    step(1, 3, 'h00000, 1, 0);
    check_eq("r0_nobubble", 32'(bus_if.out_valid), 32'd1);
    check_eq("r0_stall", 32'(bus_if.stall_cnt), 32'd1);

    // Store held under backpressure, then drained exactly once.
    step(1, 13, (7 << 10) | (9 << 5) | 3, 1, 0);
    repeat (3) begin
      step(0, 0, 0, 0, 0);
      check_eq("st_hold_valid", 32'(bus_if.out_valid), 32'd1);
      check_eq("st_hold_rd", 32'(bus_if.rd), 32'd9);
      check_eq("st_hold_rs", 32'(bus_if.rs), 32'd7);
      check_eq("st_hold_rt", 32'(bus_if.rt), 32'd0);
      check_eq("st_hold_we", 32'({bus_if.we_rf, bus_if.we_dmem}), 32'h1);
    end
    step(0, 0, 0, 1, 0);
    check_eq("st_drained", 32'(bus_if.out_valid), 32'd0);

    // Jump carries the whole field block.
    step(1, 20, 'h07ABC, 1, 0);
    check_eq("j_bamt", 32'(bus_if.bamt), 32'h7ABC);
    check_eq("j_regs", 32'({bus_if.rd, bus_if.rs, bus_if.rt}), 32'd0);
    check_eq("j_we", 32'({bus_if.we_rf, bus_if.we_dmem}), 32'd0);
    check_eq("j_cls", 32'(bus_if.out_cls), 32'd3);

    // Flush beats a pending accept.
    step(1, 3, 'h01443, 1, 0);
    step(1, 1, 'h00022, 1, 1);
    check_eq("fl_valid", 32'(bus_if.out_valid), 32'd0);
    step(0, 0, 0, 1, 0);
    check_eq("fl_noaccept", 32'(bus_if.out_valid), 32'd0);

    // Chain of dependent loads: each one bubbles, counter saturates.
    for (int i = 0; i < 2 * ((1 << CNT_W) + 2) + 4; i++)
      step(1, 12, (4 << 10) | 4, 1, 0);
    check_eq("sat_stall", 32'(bus_if.stall_cnt), 32'(CNT_TOP));

    // Random traffic with hazard-prone register choices and an async reset midway.
    do_reset();
    cur_v = 1'b0; cur_op = 0; cur_inst = 0;
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        do_reset();
        cur_v = 1'b0;
      end
      if (!(cur_v && !last_rdy)) begin
        cur_v = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 5))
          0, 1: cur_op = 12;
          2:    cur_op = 13;
          3:    cur_op = 11;
          default: cur_op = int'($urandom_range(0, 31));
        endcase
        cur_inst = (int'($urandom_range(0, 31)) << 15) | (int'($urandom_range(0, 3)) << 10)
                 | (int'($urandom_range(0, 3)) << 5) | int'($urandom_range(0, 3));
      end
      step(cur_v, cur_op, cur_inst, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
